// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the DMem two-port arbiter.
//   - arb_state_t : arbiter FSM state encoding (2 bits)
//   - ARB_PORT_*  : requester port indices
//   - FUNCT3_*    : load/store size codes, identical to the core's funct3
//                   encoding so they pass straight through to DMem.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  localparam logic ARB_PORT_CPU = 1'b0;
  localparam logic ARB_PORT_DBG = 1'b1;

  localparam logic [2:0] FUNCT3_BYTE          = 3'b000;
  localparam logic [2:0] FUNCT3_HALF          = 3'b001;
  localparam logic [2:0] FUNCT3_WORD          = 3'b010;
  localparam logic [2:0] FUNCT3_BYTE_UNSIGNED = 3'b100;
  localparam logic [2:0] FUNCT3_HALF_UNSIGNED = 3'b101;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin grant.
//   valid0, valid1 : request present on port 0 / port 1
//   lastGrant      : port granted at the previous acceptance
//   grantValid     : at least one request present
//   grant          : winning port index (meaningful when grantValid)
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic lastGrant,
  output logic grantValid,
  output logic grant
);

  assign grantValid = valid0 | valid1;

  // Under contention the port that did not win last time goes next;
  // otherwise the only requester wins.
  always_comb begin
    grant = ARB_PORT_CPU;
    if (valid0 && valid1) begin
      grant = ~lastGrant;
    end else if (valid1) begin
      grant = ARB_PORT_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-ported data memory.
// Port 0 is the load/store unit, port 1 the debug/DMA loader.
//
// Handshake: a request transfers on a rising edge where reqNValid and
// reqNReady are both 1. Ready is combinational from the valids and is only
// offered in IDLE or RESP, and only to the granted port. Requesters keep
// their fields stable while Valid & !Ready. Each accepted request yields
// exactly one respNValid pulse two cycles after acceptance.
//
// Ports:
//   clk, rstn                 clock, async active-low reset
//   req{0,1}*                 request handshake and fields
//   resp{0,1}Valid/ReadData   completion pulse and registered load data
//   mem*                      DMem interface (readData is combinational)
//   dbgState                  current FSM state, for observation only
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_SIZE = 32,
  parameter int WORD_LEN  = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req0Valid,
  output logic                 req0Ready,
  input  logic                 req0Write,
  input  logic [ADDR_SIZE-1:0] req0Addr,
  input  logic [2:0]           req0UnitSize,
  input  logic [WORD_LEN-1:0]  req0WriteData,
  output logic                 resp0Valid,
  output logic [WORD_LEN-1:0]  resp0ReadData,
  input  logic                 req1Valid,
  output logic                 req1Ready,
  input  logic                 req1Write,
  input  logic [ADDR_SIZE-1:0] req1Addr,
  input  logic [2:0]           req1UnitSize,
  input  logic [WORD_LEN-1:0]  req1WriteData,
  output logic                 resp1Valid,
  output logic [WORD_LEN-1:0]  resp1ReadData,
  output logic                 memWriteEnable,
  output logic [ADDR_SIZE-1:0] memAddr,
  output logic [2:0]           memUnitSize,
  output logic [WORD_LEN-1:0]  memWriteData,
  input  logic [WORD_LEN-1:0]  memReadData,
  output logic [1:0]           dbgState
);

  arb_state_t           state;
  logic                 lastGrant;
  logic                 latGrant;
  logic                 latWrite;
  logic [ADDR_SIZE-1:0] latAddr;
  logic [2:0]           latUnitSize;
  logic [WORD_LEN-1:0]  latWriteData;

  logic grantValid;
  logic grant;
  logic canAccept;
  logic accept;

  rr_arbiter2 u_rr (
    .valid0     (req0Valid),
    .valid1     (req1Valid),
    .lastGrant  (lastGrant),
    .grantValid (grantValid),
    .grant      (grant)
  );

  // RESP overlaps the next acceptance to sustain one access per two cycles.
  assign canAccept = (state == ARB_IDLE) || (state == ARB_RESP);
  assign accept    = canAccept && grantValid;
  assign req0Ready = accept && (grant == ARB_PORT_CPU);
  assign req1Ready = accept && (grant == ARB_PORT_DBG);

  // Address/size/data stay on the latched values outside ACCESS so DMem's
  // combinational read path never sees a request still being set up.
  // Write enable is decoded from the state register, so it falls with reset.
  assign memWriteEnable = (state == ARB_ACCESS) && latWrite;
  assign memAddr        = latAddr;
  assign memUnitSize    = latUnitSize;
  assign memWriteData   = latWriteData;
  assign dbgState       = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= ARB_IDLE;
      lastGrant     <= ARB_PORT_DBG;
      latGrant      <= ARB_PORT_CPU;
      latWrite      <= 1'b0;
      latAddr       <= '0;
      latUnitSize   <= '0;
      latWriteData  <= '0;
      resp0Valid    <= 1'b0;
      resp1Valid    <= 1'b0;
      resp0ReadData <= '0;
      resp1ReadData <= '0;
    end else begin
      resp0Valid <= 1'b0;
      resp1Valid <= 1'b0;
      case (state)
        ARB_IDLE, ARB_RESP: begin
          if (accept) begin
            lastGrant <= grant;
            latGrant  <= grant;
            if (grant == ARB_PORT_DBG) begin
              latWrite     <= req1Write;
              latAddr      <= req1Addr;
              latUnitSize  <= req1UnitSize;
              latWriteData <= req1WriteData;
            end else begin
              latWrite     <= req0Write;
              latAddr      <= req0Addr;
              latUnitSize  <= req0UnitSize;
              latWriteData <= req0WriteData;
            end
            state <= ARB_ACCESS;
          end else begin
            state <= ARB_IDLE;
          end
        end
        ARB_ACCESS: begin
          // The response pulse is registered here so it appears in RESP.
          resp0Valid <= (latGrant == ARB_PORT_CPU);
          resp1Valid <= (latGrant == ARB_PORT_DBG);
          if (!latWrite) begin
            if (latGrant == ARB_PORT_DBG) resp1ReadData <= memReadData;
            else                          resp0ReadData <= memReadData;
          end
          state <= ARB_RESP;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a byte-addressed
// little-endian DMem model (256 bytes, combinational read).
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        req0Valid, req0Ready, req0Write;
  logic [31:0] req0Addr, req0WriteData;
  logic [2:0]  req0UnitSize;
  logic        resp0Valid;
  logic [31:0] resp0ReadData;
  logic        req1Valid, req1Ready, req1Write;
  logic [31:0] req1Addr, req1WriteData;
  logic [2:0]  req1UnitSize;
  logic        resp1Valid;
  logic [31:0] resp1ReadData;
  logic        memWriteEnable;
  logic [31:0] memAddr, memWriteData, memReadData;
  logic [2:0]  memUnitSize;
  logic [1:0]  dbgState;

  dmem_arbiter #(.ADDR_SIZE(32), .WORD_LEN(32)) dut (
    .clk(clk), .rstn(rstn),
    .req0Valid(req0Valid), .req0Ready(req0Ready), .req0Write(req0Write),
    .req0Addr(req0Addr), .req0UnitSize(req0UnitSize), .req0WriteData(req0WriteData),
    .resp0Valid(resp0Valid), .resp0ReadData(resp0ReadData),
    .req1Valid(req1Valid), .req1Ready(req1Ready), .req1Write(req1Write),
    .req1Addr(req1Addr), .req1UnitSize(req1UnitSize), .req1WriteData(req1WriteData),
    .resp1Valid(resp1Valid), .resp1ReadData(resp1ReadData),
    .memWriteEnable(memWriteEnable), .memAddr(memAddr), .memUnitSize(memUnitSize),
    .memWriteData(memWriteData), .memReadData(memReadData),
    .dbgState(dbgState)
  );

  // ---------------- DMem model ----------------
  logic [7:0] mem [0:255];
  logic [7:0] ma, b0, b1, b2, b3;
  logic       pl_en;
  logic [7:0] pl_addr, pl_data;

  assign ma = memAddr[7:0];
  assign b0 = mem[ma];
  assign b1 = mem[8'(ma + 8'd1)];
  assign b2 = mem[8'(ma + 8'd2)];
  assign b3 = mem[8'(ma + 8'd3)];

  always_comb begin
    memReadData = 32'h0;
    case (memUnitSize)
      FUNCT3_BYTE:          memReadData = {{24{b0[7]}}, b0};
      FUNCT3_HALF:          memReadData = {{16{b1[7]}}, b1, b0};
      FUNCT3_WORD:          memReadData = {b3, b2, b1, b0};
      FUNCT3_BYTE_UNSIGNED: memReadData = {24'h0, b0};
      FUNCT3_HALF_UNSIGNED: memReadData = {16'h0, b1, b0};
      default:              memReadData = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (memWriteEnable) begin
      mem[ma] <= memWriteData[7:0];
      if (memUnitSize == FUNCT3_HALF || memUnitSize == FUNCT3_WORD)
        mem[8'(ma + 8'd1)] <= memWriteData[15:8];
      if (memUnitSize == FUNCT3_WORD) begin
        mem[8'(ma + 8'd2)] <= memWriteData[23:16];
        mem[8'(ma + 8'd3)] <= memWriteData[31:24];
      end
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int a);
    return 8'(a * 7 + 3);
  endfunction

  function automatic logic [31:0] exp_word(input int a);
    return {pat(a + 3), pat(a + 2), pat(a + 1), pat(a)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic idle_reqs();
    req0Valid = 1'b0; req1Valid = 1'b0;
  endtask

  task automatic drive_req(input int p, input logic w, input logic [31:0] a,
                           input logic [2:0] s, input logic [31:0] d);
    if (p == 0) begin
      req0Valid = 1'b1; req0Write = w; req0Addr = a; req0UnitSize = s; req0WriteData = d;
    end else begin
      req1Valid = 1'b1; req1Write = w; req1Addr = a; req1UnitSize = s; req1WriteData = d;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nxt0, nxt1, acc;
    logic       g;
    logic [31:0] a;
    rstn = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    req0Valid = 0; req0Write = 0; req0Addr = 0; req0UnitSize = 0; req0WriteData = 0;
    req1Valid = 0; req1Write = 0; req1Addr = 0; req1UnitSize = 0; req1WriteData = 0;

    for (int i = 0; i < 256; i++) preload(8'(i), pat(i));
    preload(8'h40, 8'h78); preload(8'h41, 8'h56);
    preload(8'h42, 8'h34); preload(8'h43, 8'h12);
    rstn = 1'b1;
    #1;

    // reset state
    check("rst_state", 32'(dbgState), 32'(ARB_IDLE));
    check("rst_we", 32'(memWriteEnable), 0);
    check("rst_addr", memAddr, 0);
    check("rst_resp0v", 32'(resp0Valid), 0);
    check("rst_resp1v", 32'(resp1Valid), 0);
    check("rst_rd0", resp0ReadData, 0);
    check("rst_rd1", resp1ReadData, 0);
    check("rst_ready0", 32'(req0Ready), 0);

    // single load, port 0
    drive_req(0, 1'b0, 32'h40, FUNCT3_WORD, 0);
    #1;
    check("t1_ready0", 32'(req0Ready), 1);
    check("t1_ready1", 32'(req1Ready), 0);
    tick(); idle_reqs(); #1;
    check("t1_state_access", 32'(dbgState), 32'(ARB_ACCESS));
    check("t1_memaddr", memAddr, 32'h40);
    check("t1_we", 32'(memWriteEnable), 0);
    check("t1_early_resp", 32'(resp0Valid), 0);
    tick(); #1;
    check("t1_resp0", 32'(resp0Valid), 1);
    check("t1_resp1", 32'(resp1Valid), 0);
    check("t1_data", resp0ReadData, 32'h12345678);
    tick(); #1;
    check("t1_pulse_once", 32'(resp0Valid), 0);
    check("t1_idle", 32'(dbgState), 32'(ARB_IDLE));

    // store byte, port 1, then signed-byte load back
    drive_req(1, 1'b1, 32'h81, FUNCT3_BYTE, 32'h000000A5);
    #1;
    check("t2_ready1", 32'(req1Ready), 1);
    check("t2_ready0", 32'(req0Ready), 0);
    tick(); idle_reqs(); #1;
    check("t2_we_on", 32'(memWriteEnable), 1);
    check("t2_addr", memAddr, 32'h81);
    check("t2_wdata", memWriteData, 32'hA5);
    tick(); #1;
    check("t2_we_off", 32'(memWriteEnable), 0);
    check("t2_resp1", 32'(resp1Valid), 1);
    check("t2_rd1_unchanged", resp1ReadData, 0);
    tick(); #1;
    check("t2_mem81", 32'(mem[8'h81]), 32'hA5);
    check("t2_mem80", 32'(mem[8'h80]), 32'(pat(8'h80)));
    drive_req(1, 1'b0, 32'h81, FUNCT3_BYTE, 0);
    tick(); idle_reqs(); tick(); #1;
    check("t2_load_resp1", 32'(resp1Valid), 1);
    check("t2_load_data", resp1ReadData, 32'hFFFFFFA5);
    check("t2_rd0_held", resp0ReadData, 32'h12345678);
    tick();

    // contention from reset: strict alternation, one access per 2 cycles
    do_reset();
    nxt0 = 0; nxt1 = 0;
    for (int i = 0; i < 8; i++) begin
      req0Valid = 1'b0; req1Valid = 1'b0;
      if (nxt0 < 4) drive_req(0, 1'b0, 32'(4 * nxt0), FUNCT3_WORD, 0);
      if (nxt1 < 4) drive_req(1, 1'b0, 32'(32'h20 + 4 * nxt1), FUNCT3_WORD, 0);
      #1;
      g = 1'(i % 2);
      check($sformatf("c%0d_ready0", i), 32'(req0Ready), 32'(g == 1'b0));
      check($sformatf("c%0d_ready1", i), 32'(req1Ready), 32'(g == 1'b1));
      if (i > 0) begin
        check($sformatf("c%0d_prev_resp", i), 32'(g ? resp0Valid : resp1Valid), 1);
        check($sformatf("c%0d_other_resp", i), 32'(g ? resp1Valid : resp0Valid), 0);
        check($sformatf("c%0d_prev_data", i), g ? resp0ReadData : resp1ReadData, exp_q.pop_front());
      end
      a = g ? 32'(32'h20 + 4 * nxt1) : 32'(4 * nxt0);
      exp_q.push_back(exp_word(int'(a)));
      if (g) nxt1++; else nxt0++;
      tick();
      req0Valid = 1'b0; req1Valid = 1'b0;
      if (nxt0 < 4) drive_req(0, 1'b0, 32'(4 * nxt0), FUNCT3_WORD, 0);
      if (nxt1 < 4) drive_req(1, 1'b0, 32'(32'h20 + 4 * nxt1), FUNCT3_WORD, 0);
      #1;
      check($sformatf("c%0d_access", i), 32'(dbgState), 32'(ARB_ACCESS));
      check($sformatf("c%0d_addr", i), memAddr, a);
      check($sformatf("c%0d_noready", i), 32'({req0Ready, req1Ready}), 0);
      tick();
    end
    idle_reqs(); #1;
    check("c_last_resp1", 32'(resp1Valid), 1);
    check("c_last_data", resp1ReadData, exp_q.pop_front());
    check("c_queue_empty", 32'(exp_q.size()), 0);
    tick();

    // back-to-back on port 0: accepts every other cycle
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      drive_req(0, 1'b0, 32'(4 * acc), FUNCT3_WORD, 0);
      #1;
      check($sformatf("b%0d_ready0", k), 32'(req0Ready), 32'(k % 2 == 0));
      if (k == 2 || k == 4) check($sformatf("b%0d_resp0", k), 32'(resp0Valid), 1);
      if (k % 2 == 0) acc++;
      tick();
    end
    idle_reqs(); tick(); #1;
    check("b_final_resp0", 32'(resp0Valid), 1);
    check("b_final_data", resp0ReadData, exp_word(8));
    tick(); #1;
    check("b_idle", 32'(dbgState), 32'(ARB_IDLE));

    // stall hold: port 1 waits while port 0 is served
    drive_req(0, 1'b0, 32'h08, FUNCT3_WORD, 0);
    #1;
    check("s_ready0", 32'(req0Ready), 1);
    tick();
    req0Valid = 1'b0;
    drive_req(1, 1'b0, 32'h24, FUNCT3_WORD, 0);
    #1;
    check("s_ready1_stall", 32'(req1Ready), 0);
    tick(); #1;
    check("s_ready1_in_resp", 32'(req1Ready), 1);
    check("s_resp0", 32'(resp0Valid), 1);
    tick(); idle_reqs(); #1;
    check("s_addr1", memAddr, 32'h24);
    tick(); #1;
    check("s_resp1", 32'(resp1Valid), 1);
    check("s_data1", resp1ReadData, exp_word(32'h24));
    tick();

    // reset during the ACCESS cycle of a store
    drive_req(0, 1'b1, 32'h90, FUNCT3_BYTE, 32'h3C);
    tick(); idle_reqs(); #1;
    check("r_we_before", 32'(memWriteEnable), 1);
    rstn = 1'b0;
    #1;
    check("r_we_async", 32'(memWriteEnable), 0);
    check("r_state_async", 32'(dbgState), 32'(ARB_IDLE));
    tick(); tick();
    rstn = 1'b1;
    #1;
    check("r_no_resp_a", 32'(resp0Valid), 0);
    tick(); #1;
    check("r_no_resp_b", 32'(resp0Valid), 0);
    check("r_mem90", 32'(mem[8'h90]), 32'(pat(8'h90)));
    check("r_addr_cleared", memAddr, 0);
    drive_req(0, 1'b0, 32'h00, FUNCT3_WORD, 0);
    drive_req(1, 1'b0, 32'h20, FUNCT3_WORD, 0);
    #1;
    check("r_first_grant0", 32'(req0Ready), 1);
    check("r_first_grant1", 32'(req1Ready), 0);
    tick(); idle_reqs(); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
